// File: rtl/down_counter_pkg.sv
// Shared types and default constants for the loadable down-counter.
package down_counter_pkg;

    localparam int unsigned DC_WIDTH = 4;
    localparam int unsigned DC_STEP  = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        EXPIRED = 2'd2
    } dc_state_t;

endpackage

// File: rtl/down_counter_underflow.sv
// Loadable down-counter with sticky underflow flag and one-cycle expiry pulse.
// Optional periodic reload when DOWN_COUNTER_AUTO_RELOAD_EN is defined.
module down_counter_underflow
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DC_WIDTH,
    parameter int unsigned STEP  = DC_STEP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             underflow_clear,
    output logic [WIDTH-1:0] counter_out,
    output logic             underflow_out,
    output logic             expired_pulse,
    output logic             zero_out,
    output logic             busy_out
);

    localparam logic [WIDTH:0] StepExt = (WIDTH + 1)'(STEP);

    dc_state_t        state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             underflow_q, underflow_d;
    logic             expired_q, expired_d;

    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             terminal;

    // Top bit of the widened subtract is the borrow: count below STEP.
    assign diff     = {1'b0, count_q} - StepExt;
    assign borrow   = diff[WIDTH];
    assign terminal = borrow || (diff[WIDTH-1:0] == '0);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        underflow_d = underflow_q;
        expired_d   = 1'b0;

        // Clear first so a set on the same edge wins.
        if (underflow_clear) begin
            underflow_d = 1'b0;
        end

        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = (load_value != '0) ? COUNT : EXPIRED;
        end else if (enable) begin
            unique case (state_q)
                COUNT: begin
                    if (!terminal) begin
                        count_d = diff[WIDTH-1:0];
                    end else begin
                        count_d   = '0;
                        expired_d = 1'b1;
                        if (borrow) begin
                            underflow_d = 1'b1;
                        end
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                        if (reload_q != '0) begin
                            count_d = reload_q;
                            state_d = COUNT;
                        end else begin
                            state_d = EXPIRED;
                        end
`else
                        state_d = EXPIRED;
`endif
                    end
                end
                EXPIRED: begin
                    underflow_d = 1'b1;
                end
                IDLE: begin
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            reload_q    <= '0;
            underflow_q <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            underflow_q <= underflow_d;
            expired_q   <= expired_d;
        end
    end

    assign counter_out   = count_q;
    assign underflow_out = underflow_q;
    assign expired_pulse = expired_q;
    assign zero_out      = (count_q == '0);
    assign busy_out      = (state_q == COUNT);

endmodule

// File: tb/tb_down_counter_underflow.sv
// Directed bench for down_counter_underflow: STEP=1 and STEP=2 instances.
module tb_down_counter_underflow;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       a_enable, a_load, a_clear;
    logic [3:0] a_load_value;
    logic [3:0] a_count;
    logic       a_uf, a_exp, a_zero, a_busy;
    logic       b_enable, b_load, b_clear;
    logic [3:0] b_load_value;
    logic [3:0] b_count;
    logic       b_uf, b_exp, b_zero, b_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    down_counter_underflow #(.WIDTH(4), .STEP(1)) dut_a (
        .clk             (clk),
        .reset           (reset),
        .enable          (a_enable),
        .load            (a_load),
        .load_value      (a_load_value),
        .underflow_clear (a_clear),
        .counter_out     (a_count),
        .underflow_out   (a_uf),
        .expired_pulse   (a_exp),
        .zero_out        (a_zero),
        .busy_out        (a_busy)
    );

    down_counter_underflow #(.WIDTH(4), .STEP(2)) dut_b (
        .clk             (clk),
        .reset           (reset),
        .enable          (b_enable),
        .load            (b_load),
        .load_value      (b_load_value),
        .underflow_clear (b_clear),
        .counter_out     (b_count),
        .underflow_out   (b_uf),
        .expired_pulse   (b_exp),
        .zero_out        (b_zero),
        .busy_out        (b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input int cnt, input bit uf, input bit ex,
                         input bit busy);
        check({tag, ".a_count"}, 32'(a_count), 32'(cnt));
        check({tag, ".a_uf"},    32'(a_uf),    32'(uf));
        check({tag, ".a_exp"},   32'(a_exp),   32'(ex));
        check({tag, ".a_busy"},  32'(a_busy),  32'(busy));
        check({tag, ".a_zero"},  32'(a_zero),  32'(cnt == 0));
    endtask

    task automatic chk_b(input string tag, input int cnt, input bit uf, input bit ex,
                         input bit busy);
        check({tag, ".b_count"}, 32'(b_count), 32'(cnt));
        check({tag, ".b_uf"},    32'(b_uf),    32'(uf));
        check({tag, ".b_exp"},   32'(b_exp),   32'(ex));
        check({tag, ".b_busy"},  32'(b_busy),  32'(busy));
        check({tag, ".b_zero"},  32'(b_zero),  32'(cnt == 0));
    endtask

    initial begin
        reset = 1'b1;
        a_enable = 1'b0; a_load = 1'b0; a_clear = 1'b0; a_load_value = 4'd0;
        b_enable = 1'b0; b_load = 1'b0; b_clear = 1'b0; b_load_value = 4'd0;
        step();
        step();
        reset = 1'b0;
        chk_a("reset", 0, 0, 0, 0);
        chk_b("reset", 0, 0, 0, 0);

        // IDLE ignores enable
        a_enable = 1'b1;
        step();
        chk_a("idle_en", 0, 0, 0, 0);

        // STEP=1 countdown from 3
        a_enable = 1'b0; a_load = 1'b1; a_load_value = 4'd3;
        step();
        chk_a("load3", 3, 0, 0, 1);
        a_load = 1'b0; a_enable = 1'b1;
        step();
        chk_a("cnt2", 2, 0, 0, 1);
        step();
        chk_a("cnt1", 1, 0, 0, 1);
        step();
        chk_a("cnt0", AUTO ? 3 : 0, 0, 1, AUTO);
        a_enable = 1'b0;
        step();
        chk_a("after_exp", AUTO ? 3 : 0, 0, 0, AUTO);

        // load 0 goes straight to EXPIRED without a pulse
        a_load = 1'b1; a_load_value = 4'd0;
        step();
        chk_a("load0", 0, 0, 0, 0);
        a_load = 1'b0; a_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a($sformatf("exp_en%0d", i), 0, 1, 0, 0);
        end
        a_enable = 1'b0; a_clear = 1'b1;
        step();
        chk_a("clear", 0, 0, 0, 0);
        a_enable = 1'b1;
        step();
        chk_a("set_wins", 0, 1, 0, 0);
        a_enable = 1'b0;
        step();
        chk_a("clear2", 0, 0, 0, 0);
        a_clear = 1'b0;

        // load beats enable, then reset mid-count
        a_load = 1'b1; a_load_value = 4'd5; a_enable = 1'b1;
        step();
        chk_a("load5_en", 5, 0, 0, 1);
        a_load = 1'b0;
        step();
        chk_a("cnt4", 4, 0, 0, 1);
        step();
        chk_a("cnt3", 3, 0, 0, 1);
        step();
        chk_a("cnt2b", 2, 0, 0, 1);
        reset = 1'b1;
        step();
        chk_a("mid_reset", 0, 0, 0, 0);
        reset = 1'b0; a_enable = 1'b0;

        // periodic reload (only reloads when the macro is defined)
        a_load = 1'b1; a_load_value = 4'd2;
        step();
        chk_a("rl_load2", 2, 0, 0, 1);
        a_load = 1'b0; a_enable = 1'b1;
        step();
        chk_a("rl_1", 1, 0, 0, 1);
        step();
        chk_a("rl_2", AUTO ? 2 : 0, 0, 1, AUTO);
        step();
        chk_a("rl_3", AUTO ? 1 : 0, !AUTO, 0, AUTO);
        step();
        chk_a("rl_4", AUTO ? 2 : 0, !AUTO, AUTO, AUTO);
        a_enable = 1'b0;

        // STEP=2: 3 -> 1 -> borrow saturates at 0 with underflow
        b_load = 1'b1; b_load_value = 4'd3;
        step();
        chk_b("b_load3", 3, 0, 0, 1);
        b_load = 1'b0; b_enable = 1'b1;
        step();
        chk_b("b_cnt1", 1, 0, 0, 1);
        step();
        chk_b("b_borrow", AUTO ? 3 : 0, 1, 1, AUTO);
        b_enable = 1'b0;
        step();
        chk_b("b_sticky", AUTO ? 3 : 0, 1, 0, AUTO);
        b_clear = 1'b1;
        step();
        chk_b("b_clear", AUTO ? 3 : 0, 0, 0, AUTO);
        b_clear = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
